// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/mux-select bundle between four requesters and the shared 4:1 mux arbiter.
// master = requester side (drives req); slave = arbiter side (drives grant, selects, valid).
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       sel_1;
  logic       sel_2;
  logic       valid;

  modport master (output req, input grant, sel_1, sel_2, valid);
  modport slave  (input req, output grant, sel_1, sel_2, valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux with a per-owner time slice; registered grant/sel/valid.
// Latency: req sampled at edge k -> grant visible after edge k; handoffs are gapless.
// Backpressure: none on req; a pending competitor forces handoff after SLICE_CYCLES owned cycles.
module mux4_rr_arbiter #(
  parameter int SLICE_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [1:0] owner_nxt;
  logic [3:0] others;
  logic [2:0] idle_pick;
  logic [2:0] next_pick;

  assign owner_nxt = owner_q + 2'd1;
  assign others    = bus.req & ~(4'b0001 << owner_q);
  assign idle_pick = rr_pick(bus.req, ptr_q);
  assign next_pick = rr_pick(others, owner_nxt);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          state_d = GRANT;
          owner_d = idle_pick[1:0];
          sel_d   = idle_pick[1:0];
          grant_d = 4'b0001 << idle_pick[1:0];
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          ptr_d = owner_nxt;
          if (next_pick[2]) begin
            owner_d = next_pick[1:0];
            sel_d   = next_pick[1:0];
            grant_d = 4'b0001 << next_pick[1:0];
            cnt_d   = '0;
          end else begin
            // sel keeps the last owner index while idle
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if ((cnt_q == CNT_MAX) && (|others)) begin
          ptr_d   = owner_nxt;
          owner_d = next_pick[1:0];
          sel_d   = next_pick[1:0];
          grant_d = 4'b0001 << next_pick[1:0];
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel_1 = sel_q[0];
  assign bus.sel_2 = sel_q[1];
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; each check compares {grant, sel_2, sel_1, valid}.
module tb_mux4_rr_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.SLICE_CYCLES(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    apply_reset();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_state got=%b exp=%b", got, 7'b0000_00_0);
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b0000_00_0) begin
        n_fail++;
        $display("FAIL idle_no_req cyc=%0d got=%b exp=%b", i, got, 7'b0000_00_0);
      end
      n_cmp++;
    end
  endtask

  task automatic test_single_c();
    logic [6:0] got;
    apply_reset();
    bus.req = 4'b0100;
    for (int e = 1; e <= 5; e++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b0100_10_1) begin
        n_fail++;
        $display("FAIL single_c_hold edge=%0d got=%b exp=%b", e, got, 7'b0100_10_1);
      end
      n_cmp++;
    end
    bus.req = 4'b0000;
    for (int e = 6; e <= 7; e++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b0000_10_0) begin
        n_fail++;
        $display("FAIL single_c_release edge=%0d got=%b exp=%b", e, got, 7'b0000_10_0);
      end
      n_cmp++;
    end
  endtask

  // All four requesting: A,B,C,D,A... each for exactly 8 edges, no gaps.
  task automatic test_slice_rotation();
    logic [6:0] got;
    logic [6:0] exp;
    logic [1:0] own;
    apply_reset();
    bus.req = 4'b1111;
    for (int e = 1; e <= 40; e++) begin
      tick();
      own = 2'((e - 1) / 8);
      exp = {4'b0001 << own, own, 1'b1};
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL slice_rotation edge=%0d got=%b exp=%b", e, got, exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_saturated_takeover();
    logic [6:0] got;
    apply_reset();
    bus.req = 4'b0010;
    for (int e = 1; e <= 20; e++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b0010_01_1) begin
        n_fail++;
        $display("FAIL sat_b_alone edge=%0d got=%b exp=%b", e, got, 7'b0010_01_1);
      end
      n_cmp++;
    end
    bus.req = 4'b1010;
    for (int e = 0; e < 3; e++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b1000_11_1) begin
        n_fail++;
        $display("FAIL sat_d_takeover step=%0d got=%b exp=%b", e, got, 7'b1000_11_1);
      end
      n_cmp++;
    end
    bus.req = 4'b0010;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0010_01_1) begin
      n_fail++;
      $display("FAIL sat_b_regrant got=%b exp=%b", got, 7'b0010_01_1);
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    logic [6:0] got;
    apply_reset();
    bus.req = 4'b1000;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b1000_11_1) begin
      n_fail++;
      $display("FAIL wrap_d_grant got=%b exp=%b", got, 7'b1000_11_1);
    end
    n_cmp++;
    bus.req = 4'b0011;
    for (int e = 0; e < 2; e++) begin
      tick();
      got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
      if (got !== 7'b0001_00_1) begin
        n_fail++;
        $display("FAIL wrap_to_a step=%0d got=%b exp=%b", e, got, 7'b0001_00_1);
      end
      n_cmp++;
    end
    bus.req = 4'b0010;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0010_01_1) begin
      n_fail++;
      $display("FAIL wrap_a_to_b got=%b exp=%b", got, 7'b0010_01_1);
    end
    n_cmp++;
  endtask

  // After C releases to idle the search starts at D, so D beats A.
  task automatic test_idle_rotation();
    logic [6:0] got;
    apply_reset();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0000_10_0) begin
      n_fail++;
      $display("FAIL rot_idle got=%b exp=%b", got, 7'b0000_10_0);
    end
    n_cmp++;
    bus.req = 4'b1001;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b1000_11_1) begin
      n_fail++;
      $display("FAIL rot_ptr_d got=%b exp=%b", got, 7'b1000_11_1);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_grant();
    logic [6:0] got;
    apply_reset();
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b1111;
    tick();
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0100_10_1) begin
      n_fail++;
      $display("FAIL midrst_c_holds got=%b exp=%b", got, 7'b0100_10_1);
    end
    n_cmp++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL midrst_cleared got=%b exp=%b", got, 7'b0000_00_0);
    end
    n_cmp++;
    tick();
    got = {bus.grant, bus.sel_2, bus.sel_1, bus.valid};
    if (got !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL midrst_a_first got=%b exp=%b", got, 7'b0001_00_1);
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req = 4'b0000;
    #1;
    test_reset();
    test_single_c();
    test_slice_rotation();
    test_saturated_takeover();
    test_wrap();
    test_idle_rotation();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input, 1-output select mux among four requesters.
- Samples four request lines and picks one owner at a time. Drives the mux selects so the owner's input (A/B/C/D) reaches Y, plus a one-hot grant back to the requesters.
- Enforces a time slice, so a requester cannot hold the mux while others wait. The ownership/handoff logic makes the block sequential.

Parameters:
- SLICE_CYCLES, 8, max consecutive grant cycles for one owner while another requester is pending; legal range 2..15.
- CNT_W, 4, width of the slice counter; must hold SLICE_CYCLES-1.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high; clears all state on the next rising edge.
- req, input, 4, request lines; bit 0=A, 1=B, 2=C, 3=D.
- grant, output, 4, one-hot current owner; all zeros when idle.
- sel_1, output, 1, mux low select = owner index bit 0.
- sel_2, output, 1, mux high select = owner index bit 1.
- valid, output, 1, high while the mux output belongs to a granted requester.

Behaviour:
- Index map:
  - A=0 (sel_2,sel_1=0,0), B=1 (0,1), C=2 (1,0), D=3 (1,1).
- Outputs:
  - All outputs are registered.
  - grant, sel_1, sel_2 and valid change only on a clk edge, together and consistently.
- Internal state:
  - FSM {IDLE, GRANT}.
  - owner[1:0].
  - ptr[1:0] = next search start.
  - cnt[CNT_W-1:0] = cycles owned.
- Reset (sync, active-high):
  - state=IDLE, grant=0000, valid=0, sel_1=0, sel_2=0, ptr=0, cnt=0.
  - Reset overrides every other event, including mid-grant.
- Search:
  - Rotating priority starting at ptr, i.e. ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - The first set req bit wins.
- IDLE:
  - If req==0000, stay in IDLE; outputs unchanged, so sel holds the last owner index.
  - Else at the edge: owner=winner, grant=onehot(winner), sel=winner, valid=1, cnt=0, go to GRANT.
  - Latency: req sampled high at edge k gives grant visible after edge k.
- GRANT: evaluated each edge, in priority order.
  1. Release: req[owner]==0. Set ptr=owner+1 and search req from owner+1, excluding owner.
     - If a winner exists: immediate handoff in the same edge to the new owner, cnt=0, stay in GRANT. There is no idle gap.
     - If no winner: IDLE, grant=0000, valid=0, sel holds.
  2. Slice expiry: cnt==SLICE_CYCLES-1 and any other req bit is set. Forced handoff to the winner searched from owner+1, ptr=owner+1, cnt=0.
  3. Otherwise: keep owner, cnt=cnt+1, saturating at SLICE_CYCLES-1.
     - With no competitor, the owner keeps the mux indefinitely.
     - Once the count is saturated, a newly arriving competitor takes over at the next edge.
- Wrap-around:
  - ptr and the search indices wrap modulo 4 (3+1=0).
- Simultaneous requests:
  - Resolved only by rotating priority; there is no fixed priority.
- Invariants:
  - grant is zero or one-hot.
  - valid==|grant.
  - When valid, {sel_2,sel_1}==index of the grant bit.
  - A requester whose req is low is never granted.

Test Plan:
- Reset, then req=0000 for 5 cycles -> grant=0000, valid=0, sel_2/sel_1=0/0 throughout.
- From reset, req=0100 at edge 1 -> after edge 1: grant=0100, sel_2=1, sel_1=0, valid=1. Drop req at edge 6 -> after edge 6: grant=0000, valid=0, sel stays 1/0.
- From reset, req=1111 held, SLICE_CYCLES=8 -> owners A,B,C,D,A... each granted exactly 8 cycles. Handoffs are back-to-back, valid never drops, sel sequence 00,01,10,11,00.
- Owner B alone, req=0010 held 20 cycles -> grant stays 0010. Then req=1010 -> grant switches to 1000 (D) at the next edge (count saturated); later D releases with B still requesting -> B regranted with no gap.
- Owner D (index 3) releases while req=0011 -> next owner A (wrap, search from 0), grant=0001, sel=00.
- Assert reset for one edge while owner C holds mid-slice with req=1111 -> after that edge: grant=0000, valid=0, sel=00, ptr=0. With req still 1111, after the next edge A is granted.
